// File: rtl/mpr121_i2c_responder.sv
// MPR121-style I2C target: byte-addressed register file with pointer write,
// data write and repeated-start read with auto-increment, on split IN/EN pads.
`timescale 1ns/1ps
module mpr121_i2c_responder #(
    parameter logic [6:0]  DEV_ADDR = 7'h5A,
    parameter int unsigned REG_AW   = 7
) (
    input  logic              i_CLK,
    input  logic              i_RSTN,
    input  logic              i_SCL_IN,
    input  logic              i_SDA_IN,
    output logic              o_SDA_OUT,
    output logic              o_SDA_EN,
    input  logic              i_HOST_WE,
    input  logic [REG_AW-1:0] i_HOST_ADDR,
    input  logic [7:0]        i_HOST_WDATA,
    output logic              o_WR_VLD,
    output logic [REG_AW-1:0] o_WR_ADDR,
    output logic [7:0]        o_WR_DATA,
    output logic              o_BUSY
);

    localparam int unsigned DEPTH = 2**REG_AW;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT, IGNORE
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        scl_sync, sda_sync;
    logic              scl_d, sda_d;
    logic              scl_rise, scl_fall, start_ev, stop_ev;
    logic [2:0]        bit_cnt;
    logic [7:0]        sr;
    logic [7:0]        rx_byte;
    logic              byte_end;
    logic              ack_phase;
    logic              rw;
    logic [REG_AW-1:0] ptr;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_byte;
    logic              sda_en_nxt, wr_fire, rd_load, addr_hit;

    assign o_SDA_OUT = 1'b0;

    // Bus idles high, so the synchronizers reset to 1 to avoid a false START.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], i_SCL_IN};
            sda_sync <= {sda_sync[0], i_SDA_IN};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_rise = scl_sync[1] & ~scl_d;
    assign scl_fall = ~scl_sync[1] & scl_d;
    assign start_ev = scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
    assign stop_ev  = scl_sync[1] & scl_d & ~sda_d & sda_sync[1];

    assign rx_byte  = {sr[6:0], sda_sync[1]};
    assign byte_end = scl_rise && (bit_cnt == 3'd7);
    assign rd_byte  = mem[ptr];

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop_ev) begin
            state_nxt = IDLE;
        end else if (start_ev) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:      if (byte_end) state_nxt = (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (scl_fall && ack_phase) state_nxt = rw ? RDATA : REG;
                REG:       if (byte_end) state_nxt = REG_ACK;
                REG_ACK:   if (scl_fall && ack_phase) state_nxt = WDATA;
                WDATA:     if (byte_end) state_nxt = WDATA_ACK;
                WDATA_ACK: if (scl_fall && ack_phase) state_nxt = WDATA;
                RDATA:     if (scl_fall && bit_cnt == 3'd7) state_nxt = RACK_WAIT;
                RACK_WAIT: begin
                    if (scl_rise && sda_sync[1])   state_nxt = IGNORE;
                    else if (scl_fall && ack_phase) state_nxt = RDATA;
                end
                IDLE, IGNORE: state_nxt = state;
                default:      state_nxt = IDLE;
            endcase
        end
    end

    // ACK states: first falling edge pulls SDA, second releases it (or starts a read byte).
    always_comb begin
        sda_en_nxt = o_SDA_EN;
        wr_fire    = 1'b0;
        rd_load    = 1'b0;
        addr_hit   = 1'b0;
        if (stop_ev || start_ev) begin
            sda_en_nxt = 1'b0;
        end else begin
            case (state)
                ADDR: addr_hit = byte_end && (rx_byte[7:1] == DEV_ADDR);
                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_en_nxt = 1'b1;
                        end else if (state == ADDR_ACK && rw) begin
                            rd_load    = 1'b1;
                            sda_en_nxt = ~rd_byte[7];
                        end else begin
                            sda_en_nxt = 1'b0;
                        end
                    end
                end
                WDATA: wr_fire = byte_end;
                RDATA: if (scl_fall) sda_en_nxt = (bit_cnt == 3'd7) ? 1'b0 : ~sr[6];
                RACK_WAIT: begin
                    if (scl_fall && ack_phase) begin
                        rd_load    = 1'b1;
                        sda_en_nxt = ~rd_byte[7];
                    end else if (scl_fall) begin
                        sda_en_nxt = 1'b0;
                    end
                end
                default: if (scl_fall) sda_en_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            o_SDA_EN  <= 1'b0;
            o_WR_VLD  <= 1'b0;
            o_WR_ADDR <= '0;
            o_WR_DATA <= '0;
            o_BUSY    <= 1'b0;
            bit_cnt   <= '0;
            sr        <= '0;
            ack_phase <= 1'b0;
            rw        <= 1'b0;
            ptr       <= '0;
        end else begin
            o_SDA_EN <= sda_en_nxt;
            o_WR_VLD <= wr_fire;
            if (wr_fire) begin
                o_WR_ADDR <= ptr;
                o_WR_DATA <= rx_byte;
            end
            if (stop_ev)       o_BUSY <= 1'b0;
            else if (addr_hit) o_BUSY <= 1'b1;

            if (start_ev || stop_ev || state_nxt != state)
                bit_cnt <= '0;
            else if ((state == ADDR || state == REG || state == WDATA) && scl_rise)
                bit_cnt <= bit_cnt + 3'd1;
            else if (state == RDATA && scl_fall)
                bit_cnt <= bit_cnt + 3'd1;

            if (rd_load)
                sr <= rd_byte;
            else if (state == RDATA && scl_fall)
                sr <= {sr[6:0], 1'b0};
            else if ((state == ADDR || state == REG || state == WDATA) && scl_rise)
                sr <= rx_byte;

            if (state_nxt != state)
                ack_phase <= 1'b0;
            else if (scl_fall && (state == ADDR_ACK || state == REG_ACK || state == WDATA_ACK))
                ack_phase <= 1'b1;
            else if (state == RACK_WAIT && scl_rise && !sda_sync[1])
                ack_phase <= 1'b1;

            if (state == ADDR && byte_end) rw <= sda_sync[1];

            if (state == REG && byte_end)
                ptr <= rx_byte[REG_AW-1:0];
            else if (wr_fire || (state == RDATA && scl_fall && bit_cnt == 3'd7))
                ptr <= ptr + REG_AW'(1);
        end
    end

    // I2C write is applied after the host write so it wins on an address collision.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            mem <= '{default: '0};
        end else begin
            if (i_HOST_WE) mem[i_HOST_ADDR] <= i_HOST_WDATA;
            if (wr_fire)   mem[ptr]         <= rx_byte;
        end
    end

endmodule

// File: tb/tb_mpr121_i2c_responder.sv
// Scoreboard bench for mpr121_i2c_responder: bit-banged I2C initiator with
// expected ACKs, read bytes and write-port events queued and matched.
`timescale 1ns/1ps
module tb_mpr121_i2c_responder;

    localparam int unsigned Q = 20;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_out, sda_en;
    logic        host_we = 1'b0;
    logic [6:0]  host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        wr_vld;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        bus_q[$];
    logic [14:0] wr_q[$];

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_en;

    mpr121_i2c_responder #(.DEV_ADDR(7'h5A), .REG_AW(7)) dut (
        .i_CLK(clk), .i_RSTN(rst_n), .i_SCL_IN(scl_m), .i_SDA_IN(sda_bus),
        .o_SDA_OUT(sda_out), .o_SDA_EN(sda_en),
        .i_HOST_WE(host_we), .i_HOST_ADDR(host_addr), .i_HOST_WDATA(host_wdata),
        .o_WR_VLD(wr_vld), .o_WR_ADDR(wr_addr), .o_WR_DATA(wr_data), .o_BUSY(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        sda_m = b;    quarter();
        scl_m = 1'b1; quarter();
        r = sda_bus;  quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic host_write(input logic [6:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        logic r, ack;
        exp_t e;
        bus_q.push_back('{$sformatf("ack_%02h", b), 32'(exp_ack)});
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, r);
        ack = ~r;
        e = bus_q.pop_front();
        check(e.tag, 32'(ack), e.val);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic nack,
                             input logic hw, input logic [6:0] ha, input logic [7:0] hd);
        logic r;
        logic [7:0] d;
        exp_t e;
        bus_q.push_back('{$sformatf("rd_%02h", exp), 32'(exp)});
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
            if (i == 7 && hw) host_write(ha, hd);
        end
        bus_bit(nack, r);
        e = bus_q.pop_front();
        check(e.tag, 32'(d), e.val);
    endtask

    always @(negedge clk) begin
        logic [14:0] ew;
        if (rst_n && wr_vld) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'({wr_addr, wr_data}), 32'h7fff_ffff);
            end else begin
                ew = wr_q.pop_front();
                check("wr_event", 32'({wr_addr, wr_data}), 32'(ew));
            end
        end
    end

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic r;
        repeat (5) @(negedge clk);
        check("rst_sda_en", 32'(sda_en), 32'd0);
        check("rst_sda_out", 32'(sda_out), 32'd0);
        check("rst_wr_vld", 32'(wr_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        quarter();

        // Pointer + data write, then read back
        wr_q.push_back({7'h5E, 8'h0C});
        i2c_start();
        send_byte(8'hB4, 1'b1);
        check("busy_addr", 32'(busy), 32'd1);
        send_byte(8'h5E, 1'b1);
        send_byte(8'h0C, 1'b1);
        i2c_stop();
        check("busy_stop1", 32'(busy), 32'd0);
        i2c_start(); send_byte(8'hB4, 1'b1); send_byte(8'h5E, 1'b1);
        i2c_start(); send_byte(8'hB5, 1'b1);
        recv_byte(8'h0C, 1'b1, 1'b0, '0, '0);
        i2c_stop();

        // Repeated-start read of host-written bytes; host overwrite mid-byte must not leak
        host_write(7'h00, 8'hA5);
        host_write(7'h01, 8'h3C);
        i2c_start(); send_byte(8'hB4, 1'b1); send_byte(8'h00, 1'b1);
        i2c_start(); send_byte(8'hB5, 1'b1);
        recv_byte(8'hA5, 1'b0, 1'b1, 7'h00, 8'hFF);
        recv_byte(8'h3C, 1'b1, 1'b0, '0, '0);
        check("sda_rel_nack", 32'(sda_en), 32'd0);
        check("busy_pre_stop", 32'(busy), 32'd1);
        i2c_stop();
        check("busy_post_stop", 32'(busy), 32'd0);

        // Address mismatch: no ACKs, no writes
        i2c_start();
        send_byte(8'hB6, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h99, 1'b0);
        check("busy_mismatch", 32'(busy), 32'd0);
        i2c_stop();

        // Pointer wrap on write and on read
        wr_q.push_back({7'h7F, 8'h11});
        wr_q.push_back({7'h00, 8'h22});
        i2c_start(); send_byte(8'hB4, 1'b1); send_byte(8'h7F, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        i2c_stop();
        i2c_start(); send_byte(8'hB4, 1'b1); send_byte(8'h7F, 1'b1);
        i2c_start(); send_byte(8'hB5, 1'b1);
        recv_byte(8'h11, 1'b0, 1'b0, '0, '0);
        recv_byte(8'h22, 1'b1, 1'b0, '0, '0);
        i2c_stop();

        // Partial write aborted by STOP; pointer preserved for a bare read
        wr_q.push_back({7'h10, 8'h77});
        i2c_start(); send_byte(8'hB4, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h77, 1'b1);
        i2c_stop();
        i2c_start(); send_byte(8'hB4, 1'b1); send_byte(8'h10, 1'b1);
        bus_bit(1'b1, r); bus_bit(1'b0, r); bus_bit(1'b1, r); bus_bit(1'b0, r);
        i2c_stop();
        i2c_start(); send_byte(8'hB5, 1'b1);
        recv_byte(8'h77, 1'b1, 1'b0, '0, '0);
        i2c_stop();

        // Async reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a;
            a = 8'hB4;
            bus_bit(a[i], r);
        end
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        check("ack_before_rst", 32'(sda_en), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("sda_en_async", 32'(sda_en), 32'd0);
        check("busy_async", 32'(busy), 32'd0);
        scl_m = 1'b0; quarter();
        scl_m = 1'b1; quarter();
        rst_n = 1'b1; quarter();
        i2c_start(); send_byte(8'hB4, 1'b1); send_byte(8'h00, 1'b1);
        i2c_start(); send_byte(8'hB5, 1'b1);
        recv_byte(8'h00, 1'b1, 1'b0, '0, '0);
        i2c_stop();

        quarter();
        check("wr_pending", 32'(wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
